// File: rtl/alu_op_defines.sv
// Shared alu_op encodings for the RV32I execute path. The ALU control
// decoder imports the same constants, so both sides agree on the codes.
package alu_op_defines;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLTU   = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_ANDN   = 4'b1010;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    // True for the three shift operations.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Iterative shifter: latches value/op/count on load, then moves at most
// SHIFT_STEP bit positions per cycle. done flags the cycle whose step
// finishes the shift; value_next is the value after that step.
module serial_shifter
    import alu_op_defines::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [3:0]               op_in,
    input  logic [XLEN-1:0]          value_in,
    input  logic [$clog2(XLEN)-1:0]  count_in,
    output logic [XLEN-1:0]          value_next,
    output logic                     done
);

    localparam int CW = $clog2(XLEN);
    // The remaining count never exceeds XLEN-1, so a larger step is clamped.
    localparam int STEP_MAX = (SHIFT_STEP < XLEN - 1) ? SHIFT_STEP : XLEN - 1;
    localparam logic [CW-1:0] STEP_C = CW'(STEP_MAX);

    logic [XLEN-1:0]        value_q;
    logic signed [XLEN-1:0] value_s;
    logic [3:0]             op_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          step_k;

    assign value_s = value_q;

    // One bounded step: k = min(count, SHIFT_STEP); SRA keeps replicating the held MSB.
    always_comb begin
        step_k = (count_q < STEP_C) ? count_q : STEP_C;
        case (op_q)
            ALU_SLL: value_next = value_q << step_k;
            ALU_SRA: value_next = value_s >>> step_k;
            default: value_next = value_q >> step_k;
        endcase
        done = (count_q == step_k);
    end

    // Control: latched op and remaining bit count, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            op_q    <= ALU_SRL;
        end else if (load) begin
            count_q <= count_in;
            op_q    <= op_in;
        end else if (count_q != '0) begin
            count_q <= count_q - step_k;
        end
    end

    // Data: the value being shifted, meaningful only while count is nonzero.
    always_ff @(posedge clk) begin
        if (load) begin
            value_q <= value_in;
        end else if (count_q != '0) begin
            value_q <= value_next;
        end
    end

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle RV32I execute unit with valid/ready on both sides.
// Non-shift ops finish in one cycle; shifts iterate through serial_shifter.
// Define SERIAL_ALU_BARREL_SHIFT_EN to use a combinational barrel shifter
// instead, making every shift single-cycle (SHIFT state unused).
module serial_alu
    import alu_op_defines::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] src_A,
    input  logic [XLEN-1:0] src_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   needs_iter;
    logic                   shift_start;
    logic                   result_load;
    logic [CW-1:0]          shamt;
    logic signed [XLEN-1:0] src_a_s;
    logic signed [XLEN-1:0] src_b_s;
    logic [XLEN-1:0]        comb_result;
    logic [XLEN-1:0]        result_next;
    logic [XLEN-1:0]        shift_next;
    logic                   shift_done;

    assign shamt   = src_B[CW-1:0];
    assign src_a_s = src_A;
    assign src_b_s = src_B;

    // Single-cycle datapath for everything that does not need iteration.
    always_comb begin
        case (alu_op)
            ALU_ADD:    comb_result = src_A + src_B;
            ALU_SUB:    comb_result = src_A - src_B;
            ALU_AND:    comb_result = src_A & src_B;
            ALU_OR:     comb_result = src_A | src_B;
            ALU_XOR:    comb_result = src_A ^ src_B;
            ALU_SLT:    comb_result = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
            ALU_SLTU:   comb_result = {{(XLEN-1){1'b0}}, (src_A < src_B)};
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
            ALU_SLL:    comb_result = src_A << shamt;
            ALU_SRL:    comb_result = src_A >> shamt;
            ALU_SRA:    comb_result = src_a_s >>> shamt;
`else
            // Reached only with shamt == 0; nonzero amounts go to the shifter.
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:    comb_result = src_A;
`endif
            ALU_ANDN:   comb_result = src_A & ~src_B;
            ALU_PASS_B: comb_result = src_B;
            default:    comb_result = '0;
        endcase
    end

`ifdef SERIAL_ALU_BARREL_SHIFT_EN
    assign needs_iter = 1'b0;
    assign shift_next = '0;
    assign shift_done = 1'b1;
`else
    assign needs_iter = is_shift_op(alu_op) && (shamt != '0);

    serial_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (shift_start),
        .op_in      (alu_op),
        .value_in   (src_A),
        .count_in   (shamt),
        .value_next (shift_next),
        .done       (shift_done)
    );
`endif

    assign shift_start = accept && needs_iter;

    // FSM state register; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and result-register load select.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        result_load = 1'b0;
        result_next = comb_result;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (needs_iter) begin
                        state_next = ST_SHIFT;
                    end else begin
                        result_load = 1'b1;
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    result_load = 1'b1;
                    result_next = shift_next;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result register, held stable through DONE until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= '0;
        end else if (result_load) begin
            alu_result <= result_next;
        end
    end

    assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_serial_alu.sv
// Randomized bench for serial_alu with a behavioural reference model,
// a per-cycle compare process and directed literal cases.
module tb_serial_alu;
    import alu_op_defines::*;

    localparam int XLEN = 32;
    localparam int STEP = 1;
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
    localparam bit ITER = 1'b0;
`else
    localparam bit ITER = 1'b1;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] src_A;
    logic [XLEN-1:0] src_B;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    int errors = 0;
    int checks = 0;

    serial_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .src_A      (src_A),
        .src_B      (src_B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [63:0] ext;
        sh  = b[4:0];
        ext = {{32{a[31]}}, a};
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:    return a << sh;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return ext[31:0] >> 0 == 0 ? 32'd0 : 32'(ext >> sh);
            ALU_ANDN:   return a & ~b;
            ALU_PASS_B: return b;
            default:    return 32'd0;
        endcase
    endfunction

    // Cycles from accept to out_valid.
    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        int sh;
        int lat;
        sh  = int'(b[4:0]);
        lat = 1;
        if (ITER && (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) && sh != 0)
            lat = 1 + (sh + STEP - 1) / STEP;
        return lat;
    endfunction

    // Model state: at most one op outstanding.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_due = 0;
    logic [31:0] m_res = '0;
    int          n_acc = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                if (cyc >= m_due && out_ready) m_busy = 1'b0;
            end else if (in_valid) begin
                m_busy = 1'b1;
                m_due  = cyc + ref_latency(alu_op, src_B);
                m_res  = ref_result(alu_op, src_A, src_B);
                n_acc++;
            end
            cyc++;
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        bit exp_ov;
        if (!reset_n) begin
            check("reset in_ready", in_ready, 1);
            check("reset out_valid", out_valid, 0);
            check("reset alu_result", alu_result, 0);
            check("reset alu_zero", alu_zero, 1);
        end else begin
            exp_ov = m_busy && (cyc >= m_due);
            check("model in_ready", in_ready, !m_busy);
            check("model out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                check("model alu_result", alu_result, m_res);
                check("model alu_zero", alu_zero, m_res == 32'd0);
            end
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        check("wait idle", in_ready, 1);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        bit seen;
        wait_idle();
        in_valid = 1'b1; alu_op = op; src_A = a; src_B = b; out_ready = 1'b1;
        @(negedge clk);
        // Scramble the inputs after accept; the result must not follow them.
        in_valid = 1'b0; alu_op = 4'($urandom); src_A = $urandom; src_B = $urandom;
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({name, " out_valid"}, seen, 1);
        check({name, " result"}, alu_result, exp_r);
        check({name, " zero"}, alu_zero, exp_r == 32'd0);
        check({name, " latency"}, lat, exp_lat);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit stale;
        int target;
        in_valid = 1'b0; alu_op = '0; src_A = '0; src_B = '0; out_ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        run_op("ADD wrap", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        run_op("SUB zero", ALU_SUB, 32'd5, 32'd5, 32'h0, 1);
        run_op("SLT", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        run_op("SLTU", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("ANDN", ALU_ANDN, 32'hFF, 32'h0F, 32'hF0, 1);
        run_op("PASS_B", ALU_PASS_B, 32'hDEAD_0000, 32'h1234, 32'h1234, 1);
        run_op("OR", ALU_OR, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1);
        run_op("undef op", 4'b1100, 32'h1234_5678, 32'h1, 32'h0, 1);
        run_op("SRA 31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, ITER ? 32 : 1);
        run_op("SLL 0", ALU_SLL, 32'hA5A5_0001, 32'h0, 32'hA5A5_0001, 1);
        run_op("SRL 0x21", ALU_SRL, 32'h8000_0003, 32'h21, 32'h4000_0001, ITER ? 2 : 1);
        run_op("SLL upper", ALU_SLL, 32'h1, 32'hFFFF_FFE4, 32'h10, ITER ? 5 : 1);

        // Backpressure: result held, no accept until after the handshake.
        wait_idle();
        in_valid = 1'b1; alu_op = ALU_XOR; src_A = 32'hF0F0_0000; src_B = 32'h0F0F_1234;
        out_ready = 1'b0;
        @(negedge clk);
        alu_op = ALU_ADD; src_A = 32'd1; src_B = 32'd2;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp result", alu_result, 32'hFFFF_1234);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp after handshake out_valid", out_valid, 0);
        check("bp after handshake in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp next op valid", out_valid, 1);
        check("bp next op result", alu_result, 32'd3);
        @(negedge clk);

        // Reset while a long shift (or a held result) is in flight.
        wait_idle();
        in_valid = 1'b1; alu_op = ALU_SRA; src_A = 32'h8000_0000; src_B = 32'd31;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("no stale result", stale, 0);

        // Random sweep.
        target = n_acc + 1000;
        for (int c = 0; c < 60000 && n_acc < target; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_op    = 4'($urandom_range(0, 15));
            src_A     = rand_operand();
            src_B     = rand_operand();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        check("sweep ops accepted", n_acc >= target, 1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && m_busy; i++) @(negedge clk);
        check("sweep drained", m_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
